// File: rtl/rr_lock_arbiter.sv
// Flat N-way round-robin mutex arbiter with an optional hold timeout and a saturating grant counter.
// All outputs are registered, so a new grant appears one clock after the request is sampled.
module rr_lock_arbiter #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         ack,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner,
  output logic                 revoke,
  output logic [CNT_W-1:0]     grant_cnt
);

  localparam int OW = $clog2(N);
  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              revoke_q, revoke_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
  logic [2*N-1:0]    req_dbl;
  logic [N-1:0]      req_rot;
  logic [N:0]        seen;
  logic [OW-1:0]     off_acc [N+1];
  logic [OW:0]       pick_sum;
  logic [OW-1:0]     pick;
  logic              any_req;

  assign req_dbl    = {req, req} >> ptr_q;
  assign req_rot    = req_dbl[N-1:0];
  assign seen[0]    = 1'b0;
  assign off_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_prio
      assign seen[gi+1]    = seen[gi] | req_rot[gi];
      assign off_acc[gi+1] = off_acc[gi] |
                             ({OW{req_rot[gi] & ~seen[gi]}} & OW'(gi));
    end
  endgenerate

  assign any_req  = seen[N];
  assign pick_sum = {1'b0, ptr_q} + {1'b0, off_acc[N]};
  assign pick     = (pick_sum >= (OW+1)'(N)) ? OW'(pick_sum - (OW+1)'(N)) : pick_sum[OW-1:0];

  logic released;
  logic timed_out;
  logic [OW-1:0] ptr_after;

  assign released  = ((req & ack_q) == '0);
  assign timed_out = (HOLD_MAX != 0) && (hold_q == HW'(HOLD_MAX));
  assign ptr_after = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      revoke_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      revoke_q <= revoke_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (released || timed_out) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d    = ack_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    revoke_d = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        ack_d = '0;
        if (any_req) begin
          ack_d        = '0;
          ack_d[pick]  = 1'b1;
          owner_d      = pick;
          hold_d       = (HOLD_MAX == 0) ? '0 : HW'(1);
          cnt_d        = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      end
      GRANT: begin
        if (released || timed_out) begin
          ack_d    = '0;
          ptr_d    = ptr_after;
          revoke_d = ~released;
        end else if (HOLD_MAX != 0) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ack_d = '0;
    endcase
    busy_d = |ack_d;
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign revoke    = revoke_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: directed stimulus pushes expected grants, a negedge monitor checks them.
// Instance a: HOLD_MAX=16, CNT_W=16. Instance b: HOLD_MAX=4, CNT_W=2 (timeout rotation and counter saturation).
module tb_rr_lock_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [7:0] req_a, req_b, ack_a, ack_b;
  logic       busy_a, busy_b, rev_a, rev_b;
  logic [2:0] own_a, own_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  rr_lock_arbiter #(.N(8), .HOLD_MAX(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .ack(ack_a), .busy(busy_a),
    .owner(own_a), .revoke(rev_a), .grant_cnt(cnt_a)
  );

  rr_lock_arbiter #(.N(8), .HOLD_MAX(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .ack(ack_b), .busy(busy_b),
    .owner(own_b), .revoke(rev_b), .grant_cnt(cnt_b)
  );

  typedef struct {
    int owner;
    int cnt;
    int len;   // 0: length not checked
    int gap;   // 0: gap not checked
    bit rev;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   total = 0;
  int   bad   = 0;

  bit   in_g  [2];
  int   len_c [2];
  int   gap_c [2];
  exp_t cur   [2];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(int d, int o, int c, int l, int g, bit r);
    exp_t e;
    e.owner = o; e.cnt = c; e.len = l; e.gap = g; e.rev = r;
    if (d == 0) sb_a.push_back(e);
    else        sb_b.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic mon(int d, logic r, logic [7:0] ack, logic busy, logic [2:0] own, logic rev, int cnt);
    exp_t e;
    bit   empty;
    if (r) begin
      in_g[d]  = 1'b0;
      gap_c[d] = 0;
      return;
    end
    chk($sformatf("busy%0d", d), int'(busy), int'(|ack));
    chk($sformatf("onehot%0d", d), ($countones(ack) <= 1) ? 1 : 0, 1);
    if (rev) chk($sformatf("revoke_ack%0d", d), int'(ack), 0);
    if (ack != 0 && !in_g[d]) begin
      empty = (d == 0) ? (sb_a.size() == 0) : (sb_b.size() == 0);
      if (empty) begin
        chk($sformatf("unexpected_grant%0d", d), int'(ack), 0);
        cur[d].owner = int'(own); cur[d].len = 0; cur[d].rev = rev;
      end else begin
        e = (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
        cur[d] = e;
        $display("dut%0d grant owner=%0d ack=%02h cnt=%0d gap=%0d", d, own, ack, cnt, gap_c[d]);
        chk($sformatf("owner%0d", d), int'(own), e.owner);
        chk($sformatf("ack%0d", d), int'(ack), 1 << e.owner);
        chk($sformatf("grant_cnt%0d", d), cnt, e.cnt);
        if (e.gap != 0) chk($sformatf("gap%0d", d), gap_c[d], e.gap);
      end
      in_g[d]  = 1'b1;
      len_c[d] = 1;
    end else if (ack != 0) begin
      len_c[d]++;
      chk($sformatf("ack_hold%0d", d), int'(ack), 1 << cur[d].owner);
    end else if (in_g[d]) begin
      if (cur[d].len != 0) chk($sformatf("len%0d", d), len_c[d], cur[d].len);
      chk($sformatf("revoke%0d", d), int'(rev), int'(cur[d].rev));
      in_g[d]  = 1'b0;
      gap_c[d] = 1;
    end else begin
      gap_c[d]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, ack_a, busy_a, own_a, rev_a, int'(cnt_a));
    mon(1, rst_b, ack_b, busy_b, own_b, rev_b, int'(cnt_b));
  end

  task automatic run_a();
    rst_a = 1'b0;
    tick(2);
    // single requester, released after 5 cycles
    push(0, 0, 1, 5, 0, 1'b0);
    req_a = 8'h01; tick(5); req_a = 8'h00; tick(4);
    // owner 2 releases while 0 and 7 wait: rotation from 3 picks 7 first
    push(0, 2, 2, 5, 0, 1'b0);
    push(0, 7, 3, 4, 2, 1'b0);
    push(0, 0, 4, 3, 2, 1'b0);
    req_a = 8'h04; tick(3); req_a = 8'h85; tick(2); req_a = 8'h81; tick(6);
    req_a = 8'h01; tick(5); req_a = 8'h00; tick(4);
    // requester 3 blips low as 5 rises: 3 -> gap -> 5 -> 3
    push(0, 3, 5, 3, 0, 1'b0);
    push(0, 5, 6, 3, 2, 1'b0);
    push(0, 3, 7, 2, 2, 1'b0);
    req_a = 8'h08; tick(3); req_a = 8'h20; tick(1); req_a = 8'h28; tick(4);
    req_a = 8'h08; tick(4); req_a = 8'h00; tick(4);
    // async reset while 4 holds the lock
    push(0, 4, 8, 0, 0, 1'b0);
    req_a = 8'h10; tick(3);
    #1 rst_a = 1'b1;
    #1;
    chk("async_ack", int'(ack_a), 0);
    chk("async_busy", int'(busy_a), 0);
    chk("async_owner", int'(own_a), 0);
    chk("async_cnt", int'(cnt_a), 0);
    req_a = 8'h30;
    push(0, 4, 1, 3, 0, 1'b0);
    push(0, 5, 2, 2, 2, 1'b0);
    tick(2);
    rst_a = 1'b0;
    tick(3); req_a = 8'h20; tick(4); req_a = 8'h00; tick(4);
  endtask

  task automatic run_b();
    rst_b = 1'b0;
    // all requesters hold forever: timeout rotation 0..7,0 with saturating counter
    for (int i = 0; i < 9; i++)
      push(1, i % 8, (i + 1 > 3) ? 3 : i + 1, (i < 8) ? 4 : 0, (i == 0) ? 0 : 2, (i < 8));
    req_b = 8'hFF;
    for (int c = 0; c < 200 && sb_b.size() != 0; c++) tick(1);
    if (sb_b.size() != 0) chk("b_grant_timeout", sb_b.size(), 0);
    req_b = 8'h00;
    tick(6);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 8'h00; req_b = 8'h00;
    tick(3);
    chk("rst_ack_a", int'(ack_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_owner_a", int'(own_a), 0);
    chk("rst_revoke_a", int'(rev_a), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_ack_b", int'(ack_b), 0);
    chk("rst_cnt_b", int'(cnt_b), 0);
    fork
      run_a();
      run_b();
    join
    tick(4);
    chk("sb_a_left", sb_a.size(), 0);
    chk("sb_b_left", sb_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
